snitch_icache_refill_arbiter: RTL and testbench

Shares the single L1 refill request port between `NR_PORTS` private L0 instruction caches. Demand refills take priority over prefetches. Demand refills are arbitrated round-robin, and a starvation counter guarantees prefetch progress. The block tags each forwarded request with `{port index, is_prefetch}`, routes L1 responses back by that ID, and caps outstanding refills per port. It sits between the L0 array and the L1 lookup stage inside the icache top level.

---
 rtl/snitch_icache_refill_arbiter.sv | 148 ++++++++++++++
 tb/tb_snitch_icache_refill_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_refill_arbiter.sv
// Refill arbiter: shares one L1 refill port among NR_PORTS L0 caches, with
// demand-over-prefetch priority, starvation relief, ID tagging and response routing.
module snitch_icache_refill_arbiter #(
  parameter int NR_PORTS        = 4,
  parameter int FETCH_AW        = 32,
  parameter int LINE_WIDTH      = 128,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 8,
  localparam int IdxW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1,
  localparam int IdW  = IdxW + 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NR_PORTS-1:0][FETCH_AW-1:0]    in_req_addr_i,
  input  logic [NR_PORTS-1:0]                  in_req_prefetch_i,
  input  logic [NR_PORTS-1:0]                  in_req_valid_i,
  output logic [NR_PORTS-1:0]                  in_req_ready_o,
  output logic [FETCH_AW-1:0]                  out_req_addr_o,
  output logic [IdW-1:0]                       out_req_id_o,
  output logic                                 out_req_valid_o,
  input  logic                                 out_req_ready_i,
  input  logic [LINE_WIDTH-1:0]                out_rsp_data_i,
  input  logic                                 out_rsp_error_i,
  input  logic [IdW-1:0]                       out_rsp_id_i,
  input  logic                                 out_rsp_valid_i,
  output logic                                 out_rsp_ready_o,
  output logic [NR_PORTS-1:0][LINE_WIDTH-1:0]  in_rsp_data_o,
  output logic [NR_PORTS-1:0]                  in_rsp_error_o,
  output logic [NR_PORTS-1:0]                  in_rsp_prefetch_o,
  output logic [NR_PORTS-1:0]                  in_rsp_valid_o,
  input  logic [NR_PORTS-1:0]                  in_rsp_ready_i
);

  localparam int CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [IdxW:0] NrP = (IdxW + 1)'(NR_PORTS);

  logic [CntW-1:0]     cnt_q [NR_PORTS];
  logic [IdxW-1:0]     rr_q;
  logic [SW-1:0]       starve_q;

  logic [IdxW-1:0]     rsp_port;
  logic [NR_PORTS-1:0] rsp_hs, elig, dem_set, pf_set, cls_set, gnt;
  logic                rsp_legal, use_pf, found, stage_free, req_hs;
  logic [IdxW-1:0]     gnt_idx, rr_nxt;
  logic [IdxW:0]       sum;

  assign rsp_port = out_rsp_id_i[IdW-1:1];

  always_comb begin
    in_rsp_valid_o    = '0;
    in_rsp_data_o     = '0;
    in_rsp_error_o    = '0;
    in_rsp_prefetch_o = '0;
    out_rsp_ready_o   = 1'b0;
    rsp_legal         = 1'b0;
    for (int i = 0; i < NR_PORTS; i++) begin
      in_rsp_data_o[i]     = out_rsp_data_i;
      in_rsp_error_o[i]    = out_rsp_error_i;
      in_rsp_prefetch_o[i] = out_rsp_id_i[0];
      if (rsp_port == IdxW'(i)) begin
        in_rsp_valid_o[i] = out_rsp_valid_i;
        out_rsp_ready_o   = in_rsp_ready_i[i];
        rsp_legal         = (cnt_q[i] != '0);
      end
    end
    rsp_hs = in_rsp_valid_o & in_rsp_ready_i;
  end

  // A credit returned in this cycle makes a full port eligible immediately.
  always_comb begin
    for (int i = 0; i < NR_PORTS; i++) begin
      elig[i] = in_req_valid_i[i] &&
                ((cnt_q[i] < CntW'(MAX_OUTSTANDING)) || rsp_hs[i]);
    end
    dem_set = elig & ~in_req_prefetch_i;
    pf_set  = elig & in_req_prefetch_i;
    use_pf  = (dem_set == '0) || ((starve_q == SW'(STARVE_LIMIT)) && (pf_set != '0));
    cls_set = use_pf ? pf_set : dem_set;
  end

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = 0; k < NR_PORTS; k++) begin
      sum = {1'b0, rr_q} + (IdxW + 1)'(k);
      if (sum >= NrP) sum = sum - NrP;
      if (!found && cls_set[sum[IdxW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = sum[IdxW-1:0];
      end
    end
    gnt        = found ? (NR_PORTS'(1) << gnt_idx) : '0;
    stage_free = !out_req_valid_o || out_req_ready_i;
    in_req_ready_o = stage_free ? gnt : '0;
    req_hs     = stage_free && found;
    rr_nxt     = (gnt_idx == IdxW'(NR_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_req_valid_o <= 1'b0;
      out_req_addr_o  <= '0;
      out_req_id_o    <= '0;
      rr_q            <= '0;
      starve_q        <= '0;
    end else begin
      if (req_hs) begin
        out_req_valid_o <= 1'b1;
        out_req_addr_o  <= in_req_addr_i[gnt_idx];
        out_req_id_o    <= {gnt_idx, in_req_prefetch_i[gnt_idx]};
        rr_q            <= rr_nxt;
      end else if (out_req_ready_i) begin
        out_req_valid_o <= 1'b0;
      end
      if (pf_set == '0) begin
        starve_q <= '0;
      end else if (req_hs) begin
        if (use_pf) starve_q <= '0;
        else if (starve_q != SW'(STARVE_LIMIT)) starve_q <= starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NR_PORTS; i++) begin
        if (req_hs && gnt[i] && !rsp_hs[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (rsp_hs[i] && !(req_hs && gnt[i]) && cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(in_req_ready_o));
  a_stage_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_req_valid_o && !out_req_ready_i |=> $stable(out_req_addr_o) && $stable(out_req_id_o));
  a_rsp_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_rsp_valid_i |-> rsp_legal);
  for (genvar g = 0; g < NR_PORTS; g++) begin : g_cnt_chk
    a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_q[g] <= CntW'(MAX_OUTSTANDING));
  end

endmodule

// File: tb/tb_snitch_icache_refill_arbiter.sv
// Directed and randomized checks of snitch_icache_refill_arbiter against a
// cycle-level reference model of the arbitration, staging and credit rules.
module tb_snitch_icache_refill_arbiter;
  localparam int N = 4, AW = 32, LW = 128, MAXO = 2, LIM = 8;

  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic [N-1:0][AW-1:0] in_req_addr = '0;
  logic [N-1:0] in_req_prefetch = '0, in_req_valid = '0, in_req_ready;
  logic [AW-1:0] out_req_addr;
  logic [2:0] out_req_id;
  logic out_req_valid, out_req_ready = 1'b0;
  logic [LW-1:0] out_rsp_data = '0;
  logic out_rsp_error = 1'b0, out_rsp_valid = 1'b0, out_rsp_ready;
  logic [2:0] out_rsp_id = '0;
  logic [N-1:0][LW-1:0] in_rsp_data;
  logic [N-1:0] in_rsp_error, in_rsp_prefetch, in_rsp_valid, in_rsp_ready = '0;

  snitch_icache_refill_arbiter #(.NR_PORTS(N), .FETCH_AW(AW), .LINE_WIDTH(LW),
    .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_req_addr_i(in_req_addr), .in_req_prefetch_i(in_req_prefetch),
    .in_req_valid_i(in_req_valid), .in_req_ready_o(in_req_ready),
    .out_req_addr_o(out_req_addr), .out_req_id_o(out_req_id),
    .out_req_valid_o(out_req_valid), .out_req_ready_i(out_req_ready),
    .out_rsp_data_i(out_rsp_data), .out_rsp_error_i(out_rsp_error),
    .out_rsp_id_i(out_rsp_id), .out_rsp_valid_i(out_rsp_valid),
    .out_rsp_ready_o(out_rsp_ready),
    .in_rsp_data_o(in_rsp_data), .in_rsp_error_o(in_rsp_error),
    .in_rsp_prefetch_o(in_rsp_prefetch), .in_rsp_valid_o(in_rsp_valid),
    .in_rsp_ready_i(in_rsp_ready));

  always #5 clk_i = ~clk_i;

  int n_assert = 0, n_fail = 0;
  int m_cnt[N];
  int m_rr, m_starve;
  bit m_vld;
  logic [AW-1:0] m_addr;
  logic [2:0] m_id;
  logic [N-1:0] obs_rdy, obs_rv;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_rr = 0; m_starve = 0; m_vld = 0; m_addr = '0; m_id = '0;
  endtask

  // One clock cycle: settle, compare against the model, then advance the model.
  task automatic step();
    int g, p;
    bit use_pf, acc;
    logic [N-1:0] el, dm, pfs, cls, rhs, exp_rdy, exp_rv;
    #2;
    p = int'(out_rsp_id[2:1]);
    for (int i = 0; i < N; i++) begin
      rhs[i] = out_rsp_valid && (p == i) && in_rsp_ready[i];
      el[i]  = in_req_valid[i] && (m_cnt[i] < MAXO || rhs[i]);
    end
    dm = el & ~in_req_prefetch;
    pfs = el & in_req_prefetch;
    use_pf = (dm == 0) || (m_starve == LIM && pfs != 0);
    cls = use_pf ? pfs : dm;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && cls[(m_rr + k) % N]) g = (m_rr + k) % N;
    acc = (!m_vld || out_req_ready) && g >= 0;
    exp_rdy = acc ? N'(1 << g) : '0;
    exp_rv = out_rsp_valid ? N'(1 << p) : '0;
    chk("in_req_ready", in_req_ready, exp_rdy);
    chk("in_rsp_valid", in_rsp_valid, exp_rv);
    chk("out_rsp_ready", out_rsp_ready, in_rsp_ready[p]);
    chk("out_req_valid", out_req_valid, m_vld);
    chk("out_req_addr", out_req_addr, m_addr);
    chk("out_req_id", out_req_id, m_id);
    chk("rr_q", 128'(dut.rr_q), 128'(m_rr));
    chk("starve_q", 128'(dut.starve_q), 128'(m_starve));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("cnt_q[%0d]", i), 128'(dut.cnt_q[i]), 128'(m_cnt[i]));
      chk($sformatf("rsp_bcast[%0d]", i), {in_rsp_data[i] ^ out_rsp_data,
          in_rsp_error[i], in_rsp_prefetch[i]}, {128'h0, out_rsp_error, out_rsp_id[0]});
    end
    obs_rdy = in_req_ready;
    obs_rv = in_rsp_valid;
    @(posedge clk_i);
    if (acc) begin
      m_vld = 1; m_addr = in_req_addr[g]; m_id = 3'(g * 2 + int'(in_req_prefetch[g]));
      m_rr = (g + 1) % N;
    end else if (out_req_ready) m_vld = 0;
    if (pfs == 0) m_starve = 0;
    else if (acc) m_starve = use_pf ? 0 : ((m_starve < LIM) ? m_starve + 1 : LIM);
    for (int i = 0; i < N; i++) begin
      if (acc && g == i && !rhs[i]) m_cnt[i]++;
      else if (rhs[i] && !(acc && g == i) && m_cnt[i] > 0) m_cnt[i]--;
    end
    #1;
  endtask

  task automatic idle();
    in_req_valid = '0; in_req_prefetch = '0; out_rsp_valid = 1'b0; in_rsp_ready = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    m_reset();
  endtask

  initial begin
    int dgr, pseen;
    logic [AW-1:0] h_addr;
    logic [2:0] h_id;
    m_reset();
    do_reset();
    chk("reset_out_valid", out_req_valid, 1'b0);
    out_req_ready = 1'b1;
    step();

    // Single port demand
    in_req_valid = 4'b0100; in_req_addr[2] = 32'h8000_0040;
    step();
    chk("t1_ready", obs_rdy, 4'b0100);
    idle();
    chk("t1_id", out_req_id, 3'b100);
    chk("t1_addr", out_req_addr, 32'h8000_0040);
    out_rsp_valid = 1'b1; out_rsp_id = 3'b100; out_rsp_error = 1'b1;
    out_rsp_data = {$urandom, $urandom, $urandom, $urandom}; in_rsp_ready = 4'hF;
    step();
    chk("t1_rsp_valid", obs_rv, 4'b0100);
    idle(); out_rsp_error = 1'b0;

    // Class priority and round-robin
    do_reset();
    in_req_valid = 4'b0111; in_req_prefetch = 4'b0010;
    for (int i = 0; i < N; i++) in_req_addr[i] = $urandom;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("t2_grant%0d", k), obs_rdy, (k == 0) ? 4'b0001 : (k == 1) ? 4'b0100 : 4'b0010);
      chk($sformatf("t2_id%0d", k), out_req_id, (k == 0) ? 3'b000 : (k == 1) ? 3'b100 : 3'b011);
      in_req_valid = in_req_valid & ~obs_rdy;
    end

    // Backpressure
    out_req_ready = 1'b0;
    in_req_valid = 4'b1000; in_req_prefetch = '0; in_req_addr[3] = 32'hdead_beef;
    h_addr = out_req_addr; h_id = out_req_id;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_stall", obs_rdy, 4'b0000);
      chk("t3_addr_hold", out_req_addr, h_addr);
      chk("t3_id_hold", out_req_id, h_id);
    end
    out_req_ready = 1'b1;
    step();
    chk("t3_release", obs_rdy, 4'b1000);
    idle();
    step();

    // Outstanding limit
    do_reset();
    in_req_valid = 4'b0010; in_req_addr[1] = 32'h0000_1000;
    step(); step(); step();
    chk("t4_stalled", obs_rdy[1], 1'b0);
    out_rsp_valid = 1'b1; out_rsp_id = 3'b010; in_rsp_ready = 4'b0010;
    step();
    chk("t4_credit_accept", obs_rdy, 4'b0010);
    idle();
    step();

    // Starvation relief
    do_reset();
    in_req_valid = 4'b1101; in_req_prefetch = 4'b1000;
    dgr = 0; pseen = 0;
    for (int k = 0; k < 20 && pseen == 0; k++) begin
      out_rsp_valid = m_vld; out_rsp_id = m_id; in_rsp_ready = 4'hF;
      step();
      if (obs_rdy[3]) pseen = 1;
      else if (obs_rdy[0] || obs_rdy[2]) dgr++;
    end
    chk("t5_demand_grants", 128'(dgr), 128'(8));
    chk("t5_pf_granted", 128'(pseen), 128'(1));
    chk("t5_starve_cleared", 128'(dut.starve_q), 128'(0));
    idle();
    out_rsp_valid = m_vld; out_rsp_id = m_id; in_rsp_ready = 4'hF;
    step();
    idle();

    // Mid-flight asynchronous reset
    do_reset();
    in_req_valid = 4'b0001; step();
    in_req_valid = 4'b0100; step(); step();
    idle();
    chk("t6_pre_cnt0", 128'(dut.cnt_q[0]), 128'(1));
    chk("t6_pre_cnt2", 128'(dut.cnt_q[2]), 128'(2));
    #2 rst_ni = 1'b0;
    #1;
    chk("t6_valid", out_req_valid, 1'b0);
    chk("t6_rr", 128'(dut.rr_q), 128'(0));
    for (int i = 0; i < N; i++) chk($sformatf("t6_cnt%0d", i), 128'(dut.cnt_q[i]), 128'(0));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    m_reset();
    step();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      int rp;
      in_req_valid = 4'($urandom);
      in_req_prefetch = 4'($urandom);
      for (int i = 0; i < N; i++) in_req_addr[i] = $urandom;
      out_req_ready = ($urandom_range(0, 3) != 0);
      rp = $urandom_range(0, N - 1);
      out_rsp_valid = (m_cnt[rp] > 0) && ($urandom_range(0, 1) == 1);
      out_rsp_id = {2'(rp), 1'($urandom)};
      out_rsp_data = {$urandom, $urandom, $urandom, $urandom};
      out_rsp_error = 1'($urandom);
      in_rsp_ready = 4'($urandom);
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
